branch_pc_unit: RTL and testbench

- Consumes the equal/less flags from the branch comparator and owns the program counter.
- Drives the comparator's signed/unsigned select from funct3.
- Resolves the outcome of conditional branches, JAL and JALR, and computes the next PC.
- Holds the PC on stall, traps misaligned targets through a two-state FSM, and keeps saturating branch and taken-branch counters for debug.

---
 rtl/branch_pc_unit.sv | 151 +++++++++++++++
 tb/tb_branch_pc_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// Branch resolution and program counter: decodes B-type/JAL/JALR outcomes, owns the PC, traps misaligned targets.
// Latency: next PC on o_pc one cycle after the decision; a misaligned transfer reaches TRAP_VEC two cycles after it.
// Backpressure: i_stall freezes PC, counters and FSM in RUN; a pending trap completes regardless of i_stall.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0010,
  parameter int          CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_insn_vld,
  input  logic             i_is_branch,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic [2:0]       i_funct3,
  input  logic             i_br_equal,
  input  logic             i_br_less,
  input  logic [31:0]      i_imm,
  input  logic [31:0]      i_rs1_data,
  output logic             o_br_un,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_pc_four,
  output logic             o_taken,
  output logic             o_illegal,
  output logic             o_misalign,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_taken_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] pc_nxt;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;

  logic        sel_jalr;
  logic        sel_jal;
  logic        sel_br;
  logic        funct3_bad;
  logic        cond_met;
  logic        active;
  logic        taken;
  logic        illegal;
  logic [31:0] target;
  logic        misaligned;
  logic        advance;
  logic        count_br;

  assign o_pc        = pc_q;
  assign o_pc_four   = pc_q + 32'd4;
  assign o_br_un     = (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
  assign o_misalign  = (state == TRAP);
  assign o_br_cnt    = br_cnt_q;
  assign o_taken_cnt = taken_cnt_q;
  assign o_taken     = taken;
  assign o_illegal   = illegal;

  // Instruction-type priority (jalr > jal > branch) and the per-funct3 branch condition.
  always_comb begin
    sel_jalr   = i_is_jalr;
    sel_jal    = !i_is_jalr && i_is_jal;
    sel_br     = !i_is_jalr && !i_is_jal && i_is_branch;
    funct3_bad = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
    cond_met   = 1'b0;
    case (i_funct3)
      3'b000:  cond_met = i_br_equal;
      3'b001:  cond_met = !i_br_equal;
      3'b100:  cond_met = i_br_less;
      3'b101:  cond_met = !i_br_less;
      3'b110:  cond_met = i_br_less;
      3'b111:  cond_met = !i_br_less;
      default: cond_met = 1'b0;
    endcase
  end

  // Outcome, target and alignment check; only a taken transfer can be misaligned.
  always_comb begin
    active     = i_insn_vld && (state == RUN);
    taken      = active && (sel_jalr || sel_jal || (sel_br && cond_met));
    illegal    = active && sel_br && funct3_bad;
    if (sel_jalr) begin
      target = (i_rs1_data + i_imm) & ~32'h1;
    end else begin
      target = pc_q + i_imm;
    end
    misaligned = taken && (target[1:0] != 2'b00);
    advance    = (state == RUN) && !i_stall;
    count_br   = advance && i_insn_vld && sel_br && !funct3_bad;
  end

  // FSM next state and next PC: a misaligned jump parks in TRAP for one cycle, then vectors.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    case (state)
      RUN: begin
        if (!i_stall) begin
          if (misaligned) begin
            state_nxt = TRAP;
          end else if (taken) begin
            pc_nxt = target;
          end else begin
            pc_nxt = pc_q + 32'd4;
          end
        end
      end
      TRAP: begin
        state_nxt = RUN;
        pc_nxt    = TRAP_VEC;
      end
      default: begin
        state_nxt = RUN;
        pc_nxt    = pc_q;
      end
    endcase
  end

  // State and PC registers; reset wins over everything, including a pending trap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= RUN;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

  // Saturating debug counters of legal resolved branches and of those taken.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else if (count_br) begin
      if (!(&br_cnt_q)) begin
        br_cnt_q <= br_cnt_q + 1'b1;
      end
      if (taken && !(&taken_cnt_q)) begin
        taken_cnt_q <= taken_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios then randomized traffic against a reference model.
// Latency: model advances once per rising edge; outputs sampled mid-cycle on the falling edge.
// Backpressure: stall is randomized; a second instance with 2-bit counters exercises saturation.
module tb_branch_pc_unit;

  localparam logic [31:0] TRAP_VEC = 32'h0000_0010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset, i_stall, i_insn_vld, i_is_branch, i_is_jal, i_is_jalr;
  logic [2:0]  i_funct3;
  logic        i_br_equal, i_br_less;
  logic [31:0] i_imm, i_rs1_data;
  logic        o_br_un, o_taken, o_illegal, o_misalign;
  logic [31:0] o_pc, o_pc_four;
  logic [15:0] o_br_cnt, o_taken_cnt;
  logic        s_br_un, s_taken, s_illegal, s_misalign;
  logic [31:0] s_pc, s_pc_four;
  logic [1:0]  s_br_cnt, s_taken_cnt;

  branch_pc_unit u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_stall(i_stall), .i_insn_vld(i_insn_vld),
    .i_is_branch(i_is_branch), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
    .i_funct3(i_funct3), .i_br_equal(i_br_equal), .i_br_less(i_br_less),
    .i_imm(i_imm), .i_rs1_data(i_rs1_data),
    .o_br_un(o_br_un), .o_pc(o_pc), .o_pc_four(o_pc_four), .o_taken(o_taken),
    .o_illegal(o_illegal), .o_misalign(o_misalign),
    .o_br_cnt(o_br_cnt), .o_taken_cnt(o_taken_cnt)
  );

  branch_pc_unit #(.CNT_W(2)) u_sat (
    .i_clk(clk), .i_reset(i_reset), .i_stall(i_stall), .i_insn_vld(i_insn_vld),
    .i_is_branch(i_is_branch), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
    .i_funct3(i_funct3), .i_br_equal(i_br_equal), .i_br_less(i_br_less),
    .i_imm(i_imm), .i_rs1_data(i_rs1_data),
    .o_br_un(s_br_un), .o_pc(s_pc), .o_pc_four(s_pc_four), .o_taken(s_taken),
    .o_illegal(s_illegal), .o_misalign(s_misalign),
    .o_br_cnt(s_br_cnt), .o_taken_cnt(s_taken_cnt)
  );

  // Reference model state
  logic [31:0] m_pc;
  bit          m_trap;
  int          m_br, m_tk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic bit cond_ok(input logic [2:0] f3, input bit eq, input bit lt);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    i_reset = 0; i_stall = 0; i_insn_vld = 1;
    i_is_branch = 0; i_is_jal = 0; i_is_jalr = 0;
    i_funct3 = 3'd0; i_br_equal = 0; i_br_less = 0;
    i_imm = 32'h0; i_rs1_data = 32'h0;
  endtask

  // One clock: predict, check mid-cycle, then advance the model on the edge.
  task automatic step();
    int kind;
    bit tk, ill, un;
    logic [31:0] tgt;
    kind = i_is_jalr ? 3 : i_is_jal ? 2 : i_is_branch ? 1 : 0;
    tk = 0; ill = 0;
    un = (i_funct3 == 3'd6) || (i_funct3 == 3'd7);
    if (!m_trap && i_insn_vld) begin
      tk  = (kind >= 2) || (kind == 1 && cond_ok(i_funct3, i_br_equal, i_br_less));
      ill = (kind == 1) && (i_funct3 == 3'd2 || i_funct3 == 3'd3);
    end
    tgt = (kind == 3) ? ((i_rs1_data + i_imm) & 32'hFFFF_FFFE) : (m_pc + i_imm);
    @(negedge clk); #1;
    check("pc", o_pc, m_pc);
    check("pc_four", o_pc_four, m_pc + 32'd4);
    check("br_un", o_br_un, un);
    check("taken", o_taken, tk);
    check("illegal", o_illegal, ill);
    check("misalign", o_misalign, m_trap);
    check("br_cnt", o_br_cnt, sat(m_br, 65535));
    check("taken_cnt", o_taken_cnt, sat(m_tk, 65535));
    check("sat_br_cnt", s_br_cnt, sat(m_br, 3));
    check("sat_taken_cnt", s_taken_cnt, sat(m_tk, 3));
    @(posedge clk);
    if (i_reset) begin
      m_pc = 32'h0; m_trap = 0; m_br = 0; m_tk = 0;
    end else if (m_trap) begin
      m_pc = TRAP_VEC; m_trap = 0;
    end else if (!i_stall) begin
      if (tk && tgt[1:0] != 2'b00) m_trap = 1;
      else if (tk) m_pc = tgt;
      else m_pc = m_pc + 32'd4;
      if (i_insn_vld && kind == 1 && !ill) begin
        m_br++;
        if (tk) m_tk++;
      end
    end
    #1;
  endtask

  initial begin
    idle();
    i_reset = 1;
    repeat (2) @(posedge clk);
    #1;
    m_pc = 32'h0; m_trap = 0; m_br = 0; m_tk = 0;
    step();                       // reset still asserted: reset state checked
    check("reset_pc", o_pc, 32'h0);
    check("reset_misalign", o_misalign, 1'b0);
    idle();
    repeat (3) step();
    check("idle_pc", o_pc, 32'hC);
    check("idle_br_cnt", o_br_cnt, 16'd0);

    // Jump to 0x100 then BEQ taken and not taken
    i_is_jal = 1; i_imm = 32'hF4; step(); idle();
    check("jal_pc", o_pc, 32'h100);
    i_is_branch = 1; i_funct3 = 3'd0; i_br_equal = 1; i_imm = 32'h20;
    #1 check("beq_taken", o_taken, 1'b1);
    step();
    check("beq_pc", o_pc, 32'h120);
    check("beq_br_cnt", o_br_cnt, 16'd1);
    check("beq_taken_cnt", o_taken_cnt, 16'd1);
    i_br_equal = 0; step(); idle();
    check("beq_nt_pc", o_pc, 32'h124);
    check("beq_nt_taken_cnt", o_taken_cnt, 16'd1);

    // funct3 sweep with less toggled
    for (int f = 0; f < 8; f++) begin
      for (int l = 0; l < 2; l++) begin
        idle(); i_is_branch = 1; i_funct3 = f[2:0]; i_br_less = l[0];
        i_br_equal = l[0]; i_imm = 32'h8;
        step();
      end
    end
    idle(); i_is_branch = 1; i_funct3 = 3'b010;
    #1 check("illegal_010", o_illegal, 1'b1);
    check("br_un_010", o_br_un, 1'b0);
    i_funct3 = 3'b110;
    #1 check("br_un_110", o_br_un, 1'b1);
    idle();

    // JALR aligned then misaligned
    i_is_jalr = 1; i_rs1_data = 32'h203; i_imm = 32'h1; step();
    check("jalr_pc", o_pc, 32'h204);
    i_rs1_data = 32'h201; step(); idle();
    check("trap_hold_pc", o_pc, 32'h204);
    check("trap_misalign", o_misalign, 1'b1);
    step();
    check("trap_vec_pc", o_pc, 32'h10);
    check("trap_misalign_clr", o_misalign, 1'b0);

    // Stall during a taken JAL
    i_is_jal = 1; i_imm = 32'h40; i_stall = 1;
    repeat (3) step();
    check("stall_pc", o_pc, 32'h10);
    i_stall = 0; step(); idle();
    check("stall_release_pc", o_pc, 32'h50);

    // Reset during TRAP
    i_is_jalr = 1; i_rs1_data = 32'h201; i_imm = 32'h1; step(); idle();
    i_reset = 1; step(); idle();
    check("rst_trap_pc", o_pc, 32'h0);
    check("rst_trap_misalign", o_misalign, 1'b0);

    // Counter saturation on the 2-bit instance
    i_is_branch = 1; i_funct3 = 3'd0; i_br_equal = 0; i_imm = 32'h4;
    repeat (5) step(); idle();
    check("sat_br_3", s_br_cnt, 2'd3);
    check("wide_br_5", o_br_cnt, 16'd5);

    // PC wrap
    i_is_jalr = 1; i_rs1_data = 32'hFFFF_FFFC; i_imm = 32'h0; step(); idle();
    check("wrap_top", o_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_zero", o_pc, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      i_reset     = ($urandom_range(0, 63) == 0);
      i_stall     = ($urandom_range(0, 4) == 0);
      i_insn_vld  = ($urandom_range(0, 7) != 0);
      i_is_branch = ($urandom_range(0, 1) == 0);
      i_is_jal    = ($urandom_range(0, 6) == 0);
      i_is_jalr   = ($urandom_range(0, 6) == 0);
      i_funct3    = 3'($urandom_range(0, 7));
      i_br_equal  = 1'($urandom_range(0, 1));
      i_br_less   = 1'($urandom_range(0, 1));
      i_imm       = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) i_imm[1:0] = 2'($urandom_range(0, 3));
      i_rs1_data  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) i_rs1_data[1:0] = 2'($urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
